// File: rtl/spi_host_master.sv
`default_nettype none
// ============================================================================
// Module   : spi_host_master
// Function : SPI mode-3 initiator; bursts of 16-bit MSB-first words framed
//            by a single CSN-low window, with a word-load handshake upstream.
// Revision : 1.0 - initial release
// ============================================================================
module spi_host_master #(
  parameter int CLK_DIV    = 2,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_words,
  input  logic [15:0]      tx_data,
  output logic             word_load,
  output logic [15:0]      rx_data,
  output logic             rx_valid,
  output logic             busy,
  output logic             done,
  output logic             spi_sck,
  output logic             spi_csn,
  output logic             spi_mosi,
  input  logic             spi_miso
);

  // One shared cycle counter times both the SCK half-periods and the gap.
  localparam int c_cnt_max = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
  localparam int c_div_w   = $clog2(c_cnt_max + 1);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(CLK_DIV - 1);
  localparam logic [c_div_w-1:0] c_gap_last =
    c_div_w'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CS_SETUP = 3'd1,
    S_SCK_LOW  = 3'd2,
    S_SCK_HIGH = 3'd3,
    S_WORD_GAP = 3'd4,
    S_CS_HOLD  = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [c_div_w-1:0] div_q, div_d;
  logic [3:0]         bit_q, bit_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [15:0]        tx_shift_q, tx_shift_d;
  logic [15:0]        rx_shift_q, rx_shift_d;
  logic [15:0]        rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               word_load_q, word_load_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               sck_q, sck_d;
  logic               csn_q, csn_d;
  logic               mosi_q, mosi_d;

  logic               w_div_end;
  logic               w_word_end;
  logic               w_more;
  logic               w_load;
  logic               w_go_low;
  logic [15:0]        w_src;

  // Next-state and next-output computation for the whole frame sequencer.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    bit_d       = bit_q;
    words_d     = words_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    word_load_d = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    sck_d       = sck_q;
    csn_d       = csn_q;
    mosi_d      = mosi_q;
    w_go_low    = 1'b0;

    w_div_end  = (div_q == c_div_last);
    // Word end is the cycle right after the 16th rising edge was issued.
    w_word_end = (state_q == S_SCK_HIGH) && (bit_q == 4'd15) && (div_q == '0);
    // With CLK_DIV=1 the word-end cycle is also the last high cycle, so the
    // counter has not been decremented yet when the exit decision is made.
    w_more     = w_word_end ? (words_q > CNT_W'(1)) : (words_q != '0);
    w_load     = w_word_end && (words_q > CNT_W'(1));
    // A word loaded on the same edge as a falling SCK must drive MOSI directly.
    w_src      = w_load ? tx_data : tx_shift_q;

    if (w_word_end) begin
      rx_valid_d = 1'b1;
      rx_data_d  = rx_shift_q;
      words_d    = words_q - CNT_W'(1);
      if (w_load) begin
        tx_shift_d  = tx_data;
        word_load_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (start && (num_words != '0)) begin
          words_d     = num_words;
          tx_shift_d  = tx_data;
          word_load_d = 1'b1;
          csn_d       = 1'b0;
          busy_d      = 1'b1;
          mosi_d      = tx_data[15];
          div_d       = '0;
          bit_d       = 4'd0;
          state_d     = S_CS_SETUP;
        end
      end
      S_CS_SETUP: begin
        if (w_div_end) begin
          div_d    = '0;
          w_go_low = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SCK_LOW: begin
        if (w_div_end) begin
          div_d      = '0;
          sck_d      = 1'b1;
          rx_shift_d = {rx_shift_q[14:0], spi_miso};
          state_d    = S_SCK_HIGH;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_SCK_HIGH: begin
        if (w_div_end) begin
          div_d = '0;
          if (bit_q == 4'd15) begin
            bit_d = 4'd0;
            if (!w_more) begin
              state_d = S_CS_HOLD;
            end else if (GAP_CYCLES == 0) begin
              w_go_low = 1'b1;
            end else begin
              state_d = S_WORD_GAP;
            end
          end else begin
            bit_d    = bit_q + 4'd1;
            w_go_low = 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_WORD_GAP: begin
        if (div_q == c_gap_last) begin
          div_d    = '0;
          w_go_low = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_CS_HOLD: begin
        if (w_div_end) begin
          div_d   = '0;
          csn_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          mosi_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Falling SCK edge: present the next MSB and advance the TX shifter.
    if (w_go_low) begin
      state_d    = S_SCK_LOW;
      sck_d      = 1'b0;
      mosi_d     = w_src[15];
      tx_shift_d = {w_src[14:0], 1'b0};
    end
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      div_q       <= '0;
      bit_q       <= 4'd0;
      words_q     <= '0;
      tx_shift_q  <= 16'h0000;
      rx_shift_q  <= 16'h0000;
      rx_data_q   <= 16'h0000;
      rx_valid_q  <= 1'b0;
      word_load_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      sck_q       <= 1'b1;
      csn_q       <= 1'b1;
      mosi_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      words_q     <= words_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      word_load_q <= word_load_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      sck_q       <= sck_d;
      csn_q       <= csn_d;
      mosi_q      <= mosi_d;
    end
  end

  assign word_load = word_load_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign spi_sck   = sck_q;
  assign spi_csn   = csn_q;
  assign spi_mosi  = mosi_q;

endmodule
`default_nettype wire
